dpram_stream_reader: RTL and testbench

Read-side controller for the dual-port sample RAM. It accepts a block request (start address and word count) and drives the RAM read port's address. It absorbs the RAM's fixed read latency and emits the words in address order as a valid/ready stream with a last-word flag. It sits between the port-B side of the capture buffer and downstream processing, and lets consumers apply backpressure without losing RAM data.

---
 rtl/dpram_stream_reader_pkg.sv | 23 ++
 rtl/dpram_rd_skid_fifo.sv | 84 ++++++++
 rtl/dpram_stream_reader.sv | 156 +++++++++++++++
 tb/tb_dpram_stream_reader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_stream_reader_pkg.sv
// -----------------------------------------------------------------------------
// dpram_stream_reader_pkg
// Shared definitions for the dual-port RAM stream reader:
//   - state_t    : controller states (IDLE / READ / DRAIN / DONE)
//   - fifo_depth : output FIFO depth for a given RAM read latency
// -----------------------------------------------------------------------------
package dpram_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Two slots per latency stage plus one: enough to hold every in-flight
    // read plus the presented word, so issue never has to bubble when the
    // consumer keeps m_ready high.
    function automatic int fifo_depth(input int rd_latency);
        return 2 * (rd_latency + 1);
    endfunction

endpackage

// File: rtl/dpram_rd_skid_fifo.sv
// -----------------------------------------------------------------------------
// dpram_rd_skid_fifo
// Synchronous FIFO whose read data comes straight from storage flops.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   flush       drop all contents at the next edge (wins over wr_en/rd_en)
//   wr_en       push wr_data (caller guarantees the FIFO is not full)
//   wr_data     data to push
//   rd_en       pop the head word if one is present
//   rd_data     head word
//   rd_valid    FIFO not empty
//   count       current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module dpram_rd_skid_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        do_pop   = rd_en && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en)  wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CW'(wr_en) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is reset so the head word (and thus m_data) reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en && !flush) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign rd_valid = (count_q != '0);
    assign count    = count_q;

endmodule

// File: rtl/dpram_stream_reader.sv
// -----------------------------------------------------------------------------
// dpram_stream_reader
// Reads a block of words from the RAM read port and streams them out in
// address order, absorbing the RAM's fixed read latency.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request pulse, sampled only in IDLE
//   start_addr, length  block start address and word count (0..2^ADDR_WIDTH)
//   abort               cancel the active transfer (READ/DRAIN only)
//   busy, done          state != IDLE / one-cycle completion pulse
//   ram_addr            RAM read address; ram_rd_data returns RD_LATENCY later
//   m_data, m_valid, m_ready, m_last   output stream
//   dbg_state           current controller state
//
// Stream handshake: a word transfers on a cycle where m_valid && m_ready.
// Once m_valid is high, m_data/m_last hold and m_valid stays high until that
// transfer happens; the only exception is abort, which drops m_valid.
// -----------------------------------------------------------------------------
module dpram_stream_reader
    import dpram_stream_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [1:0]            dbg_state
);

    localparam int FIFO_DEPTH = fifo_depth(RD_LATENCY);
    localparam int CW         = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W      = ADDR_WIDTH + 1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [CNT_W-1:0]      issue_left_q, issue_left_d;
    logic [CNT_W-1:0]      out_left_q, out_left_d;
    logic [RD_LATENCY-1:0] sr_q, sr_d;

    logic                  issue, room, handshake, kill, flush;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_valid;
    logic [DATA_WIDTH-1:0] fifo_data;

    // Reads already issued but not yet written into the FIFO.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(sr_q[i]);
    end

    // Reserve a FIFO slot for every read in flight so a returning word always
    // has somewhere to land, whatever the consumer does meanwhile.
    assign room      = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
    assign handshake = fifo_valid && m_ready;
    assign kill      = abort && ((state_q == ST_READ) || (state_q == ST_DRAIN));

    always_comb begin
        state_d      = state_q;
        ram_addr_d   = ram_addr_q;
        issue_left_d = issue_left_q;
        out_left_d   = out_left_q;
        flush        = 1'b0;
        issue        = (state_q == ST_READ) && !abort && room;
        // sr_q[k] marks that ram_rd_data is valid k+1 cycles after an issue.
        sr_d         = RD_LATENCY'({sr_q, issue});

        if (handshake) out_left_d = out_left_q - CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ram_addr_d   = start_addr;
                    issue_left_d = length;
                    out_left_d   = length;
                    state_d      = (length == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (issue) begin
                    ram_addr_d   = ram_addr_q + ADDR_WIDTH'(1);
                    issue_left_d = issue_left_q - CNT_W'(1);
                    if (issue_left_q == CNT_W'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (handshake && m_last) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Abort discards queued words and any reads still in the RAM pipe.
        if (kill) begin
            state_d      = ST_IDLE;
            flush        = 1'b1;
            sr_d         = '0;
            issue_left_d = '0;
            out_left_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ram_addr_q   <= '0;
            issue_left_q <= '0;
            out_left_q   <= '0;
            sr_q         <= '0;
        end else begin
            state_q      <= state_d;
            ram_addr_q   <= ram_addr_d;
            issue_left_q <= issue_left_d;
            out_left_q   <= out_left_d;
            sr_q         <= sr_d;
        end
    end

    dpram_rd_skid_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .wr_en    (sr_q[RD_LATENCY-1]),
        .wr_data  (ram_rd_data),
        .rd_en    (m_ready),
        .rd_data  (fifo_data),
        .rd_valid (fifo_valid),
        .count    (fifo_count)
    );

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign ram_addr  = ram_addr_q;
    assign m_data    = fifo_data;
    assign m_valid   = fifo_valid;
    assign m_last    = fifo_valid && (out_left_q == CNT_W'(1));
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dpram_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_dpram_stream_reader
// Drives two readers side by side (read latency 1 and 2) from the same
// stimulus, each attached to its own RAM model over one shared memory image.
// -----------------------------------------------------------------------------
module tb_dpram_stream_reader;

    localparam int BUDGET = 4000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  start_addr;
    logic [10:0] length;
    logic        abort;
    logic        m_ready;

    logic [1:0]  busy_w, done_w, m_valid_w, m_last_w;
    logic [9:0]  ram_addr0, ram_addr1;
    logic [15:0] rd0, rd1, rd1_s1;
    logic [15:0] m_data_w [2];
    logic [1:0]  dbg0, dbg1;

    logic [15:0] mem [1024];

    logic [16:0] exp_q0[$];
    logic [16:0] exp_q1[$];

    int total;
    int bad;
    bit last_aborted;

    // monitor history
    logic [1:0]  prev_v;
    logic [1:0]  prev_l;
    logic [15:0] prev_d [2];
    logic        prev_r;
    logic        prev_abort;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM models ----------------
    always @(posedge clk) begin
        rd0    <= mem[ram_addr0];
        rd1_s1 <= mem[ram_addr1];
        rd1    <= rd1_s1;
    end

    dpram_stream_reader #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .RD_LATENCY(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .length(length), .abort(abort), .busy(busy_w[0]), .done(done_w[0]),
        .ram_addr(ram_addr0), .ram_rd_data(rd0), .m_data(m_data_w[0]),
        .m_valid(m_valid_w[0]), .m_ready(m_ready), .m_last(m_last_w[0]),
        .dbg_state(dbg0)
    );

    dpram_stream_reader #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .RD_LATENCY(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .length(length), .abort(abort), .busy(busy_w[1]), .done(done_w[1]),
        .ram_addr(ram_addr1), .ram_rd_data(rd1), .m_data(m_data_w[1]),
        .m_valid(m_valid_w[1]), .m_ready(m_ready), .m_last(m_last_w[1]),
        .dbg_state(dbg1)
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, k, act, exp);
        end
    endtask

    task automatic pop_cmp(input int k, input logic [16:0] got);
        logic [16:0] e;
        bit have;
        have = 1'b0;
        e    = '0;
        if (k == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
        if (k == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
        total++;
        if (!have) begin
            bad++;
            $display("FAIL beat dut%0d: got last/data %h, expected no beat", k, got);
        end else if (got !== e) begin
            bad++;
            $display("FAIL beat dut%0d: got last/data %h expected %h", k, got, e);
        end
    endtask

    function automatic logic ready_for(input int mode, input int t);
        case (mode)
            0:       return 1'b1;
            1:       return (t % 3) == 0;
            2:       return 1'($urandom_range(0, 1));
            default: return 1'b0;
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (prev_v[k] && !prev_r && !prev_abort) begin
                    check("hold_valid", k, 32'(m_valid_w[k]), 32'd1);
                    check("hold_data", k, 32'(m_data_w[k]), 32'(prev_d[k]));
                    check("hold_last", k, 32'(m_last_w[k]), 32'(prev_l[k]));
                end
                if (m_valid_w[k] && m_ready) pop_cmp(k, {m_last_w[k], m_data_w[k]});
                prev_v[k] = m_valid_w[k];
                prev_l[k] = m_last_w[k];
                prev_d[k] = m_data_w[k];
            end
            if (dut0.u_fifo.wr_en && !dut0.u_fifo.flush)
                check("no_overflow", 0,
                      32'(dut0.u_fifo.count == 3'd4 && !(dut0.u_fifo.rd_en && dut0.u_fifo.rd_valid)), 32'd0);
            if (dut1.u_fifo.wr_en && !dut1.u_fifo.flush)
                check("no_overflow", 1,
                      32'(dut1.u_fifo.count == 3'd6 && !(dut1.u_fifo.rd_en && dut1.u_fifo.rd_valid)), 32'd0);
            prev_r     = m_ready;
            prev_abort = abort;
        end else begin
            prev_v     = '0;
            prev_abort = 1'b0;
        end
    end

    // ---------------- driver ----------------
    task automatic run_xfer(input int addr, input int len, input int rmode,
                            input int abort_at, input int restart_at);
        int fv[2], lc[2], dc[2], nd[2], nb[2];
        int ab_cyc;
        int t;
        bit fin;
        for (int k = 0; k < 2; k++) begin
            fv[k] = -1; lc[k] = -1; dc[k] = -1; nd[k] = 0; nb[k] = 0;
        end
        ab_cyc = -1;
        // reference model: word i comes from address (addr+i) mod 1024
        for (int i = 0; i < len; i++) begin
            logic [9:0] a;
            a = 10'(addr + i);
            exp_q0.push_back({(i == len - 1), mem[a]});
            exp_q1.push_back({(i == len - 1), mem[a]});
        end
        fin = 1'b0;
        t   = 0;
        while (t < BUDGET && !fin) begin
            start      = (t == 0) || (t == restart_at && busy_w == 2'b11);
            start_addr = (t == 0) ? 10'(addr) : 10'(addr + 37);
            length     = (t == 0) ? 11'(len) : 11'd5;
            abort      = 1'b0;
            if (t == abort_at && busy_w == 2'b11 && done_w == 2'b00) begin
                abort  = 1'b1;
                ab_cyc = t;
            end
            m_ready = ready_for(rmode, t);
            for (int k = 0; k < 2; k++) begin
                if (m_valid_w[k] && fv[k] < 0) fv[k] = t;
                if (m_valid_w[k] && m_last_w[k] && m_ready) lc[k] = t;
                if (done_w[k]) begin nd[k]++; dc[k] = t; end
                if (busy_w[k]) nb[k]++;
            end
            if (ab_cyc >= 0 && t == ab_cyc + 1) begin
                exp_q0.delete();
                exp_q1.delete();
                for (int k = 0; k < 2; k++) begin
                    check("abort_busy", k, 32'(busy_w[k]), 32'd0);
                    check("abort_valid", k, 32'(m_valid_w[k]), 32'd0);
                end
            end
            if (t > 0 && busy_w == 2'b00) fin = 1'b1;
            @(posedge clk); #1;
            t++;
        end
        start = 1'b0;
        abort = 1'b0;
        total++;
        if (!fin) begin
            bad++;
            $display("FAIL timeout: transfer addr=%0h len=%0d still busy after %0d cycles", addr, len, BUDGET);
        end
        last_aborted = (ab_cyc >= 0);
        for (int k = 0; k < 2; k++) begin
            if (last_aborted) begin
                check("abort_no_done", k, 32'(nd[k]), 32'd0);
            end else begin
                check("done_count", k, 32'(nd[k]), 32'd1);
                check("queue_empty", k, (k == 0) ? 32'(exp_q0.size()) : 32'(exp_q1.size()), 32'd0);
                if (rmode == 0 && len == 0) begin
                    check("zero_done_cyc", k, 32'(dc[k]), 32'd1);
                    check("zero_busy_cycles", k, 32'(nb[k]), 32'd1);
                    check("zero_no_valid", k, 32'(fv[k]), 32'hffffffff);
                end else if (rmode == 0) begin
                    check("first_valid_cyc", k, 32'(fv[k]), 32'(2 + (k + 1)));
                    check("last_cyc", k, 32'(lc[k]), 32'(1 + (k + 1) + len));
                    check("done_cyc", k, 32'(dc[k]), 32'(2 + (k + 1) + len));
                end
            end
        end
        exp_q0.delete();
        exp_q1.delete();
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        start_addr = '0;
        length = '0;
        abort = 1'b0;
        m_ready = 1'b0;
        last_aborted = 1'b0;
        for (int a = 0; a < 1024; a++) mem[a] = 16'(a);

        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_busy", k, 32'(busy_w[k]), 32'd0);
            check("rst_done", k, 32'(done_w[k]), 32'd0);
            check("rst_valid", k, 32'(m_valid_w[k]), 32'd0);
            check("rst_last", k, 32'(m_last_w[k]), 32'd0);
            check("rst_data", k, 32'(m_data_w[k]), 32'd0);
        end
        check("rst_ram_addr", 0, 32'(ram_addr0), 32'd0);
        check("rst_ram_addr", 1, 32'(ram_addr1), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_xfer(32'h010, 8, 0, -1, -1);
        run_xfer(32'h010, 8, 1, -1, -1);
        run_xfer(32'h3FE, 4, 0, -1, -1);
        run_xfer(32'h000, 0, 0, -1, -1);
        run_xfer(32'h020, 16, 3, 6, -1);
        check("abort_taken", 0, 32'(last_aborted), 32'd1);
        run_xfer(32'h100, 2, 0, -1, -1);
        run_xfer(32'h200, 1024, 0, -1, 100);

        for (int a = 0; a < 1024; a++) mem[a] = 16'($urandom);
        for (int n = 0; n < 14; n++) begin
            int len;
            int ab;
            len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 300)) : int'($urandom_range(0, 40));
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len + 6)) : -1;
            run_xfer(int'($urandom_range(0, 1023)), len, int'($urandom_range(0, 2)), ab,
                     int'($urandom_range(2, 30)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
